ascon_serial_host: RTL
======================

Name: ascon_serial_host

Overview:
- Host-side driver for the serial Ascon decryption core (`Ascon`, TI/FP variants).
- Accepts parallel key, nonce, associated data and ciphertext from a start/done handshake. Shifts them into the core's serial inputs, together with LFSR-generated random shares.
- Pulses decryption start, waits for decryption ready, then deserializes the plaintext and tag back to parallel registers.
- It is the counterpart of the core's serial interface: it drives what the core samples and samples what the core drives.

Parameters:
- K, 128, key width.
- L, 40, associated-data width.
- Y, 40, ciphertext/plaintext width.
- MAX, max(K,L,Y), number of shift cycles for both load and read.
- START_HOLD, 3, cycles decryption start is held high.
- READ_DELAY, 2, cycles between ready observed and the first read cycle.
- TIMEOUT, 4096, maximum WAIT cycles before error.
- SEED, 32'hACE1_5EED, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- key_i  in  K  key.
- nonce_i  in  128  nonce.
- ad_i  in  L  associated data.
- ct_i  in  Y  ciphertext.
- busy  out  1  high in every state except IDLE and ERR.
- done  out  1  one-cycle pulse when pt_o/tag_o are valid.
- err  out  1  timeout flag; sticky until the next accepted start.
- pt_o  out  Y  captured plaintext.
- tag_o  out  128  captured tag.
- cycles_o  out  16  clock cycles from the first START cycle to ready observed.
- keyxSO, noncexSO, associated_dataxSO, cipher_textxSO  out  3 each  [0]=data bit, [2:1]=random shares.
- r_64xSO  out  7  random.
- r_128xSO  out  1  random.
- r_ptxSO  out  1  random.
- decryption_startxSO  out  1  core start.
- plain_textxSI  in  1  core serial plaintext.
- tagxSI  in  1  core serial tag.
- decryption_readyxSI  in  1  core ready.

Behaviour:
- Reset (async, rst=0): every output 0, state IDLE, counters 0, LFSR=SEED, pt_o/tag_o/cycles_o cleared. Reset mid-operation aborts immediately; there is no resume.
- State machine: IDLE -> LOAD -> START -> WAIT -> DELAY -> READ -> DONE -> IDLE. WAIT -> ERR on timeout; ERR -> LOAD on start.
- IDLE/ERR: when start=1, latch key_i, nonce_i, ad_i and ct_i into internal registers, clear err and cycles_o, set ctr=0, go to LOAD. Inputs are ignored after the latch. start is ignored while busy.
- LOAD: exactly MAX cycles, ctr=0..MAX-1, one bit per cycle, MSB first, registered outputs:
  - keyxSO[0]=key[K-1-ctr] if ctr<K, else 0.
  - noncexSO[0]=nonce[127-ctr] if ctr<128, else 0.
  - associated_dataxSO[0]=ad[L-1-ctr] if ctr<L, else 0.
  - cipher_textxSO[0]=ct[Y-1-ctr] if ctr<Y, else 0.
- Random lanes (every LOAD cycle):
  - 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, advances once per LOAD cycle.
  - Low 17 bits map MSB to LSB as {r_128, r_pt, r_64[6:0], key[2:1], ad[2:1], ct[2:1], nonce[2:1]}.
  - Outside LOAD, all random lanes and all [0] lanes are 0.
- START: decryption_startxSO=1 for START_HOLD cycles; cycles_o counts from the first START cycle.
- WAIT: decryption_startxSO=0; cycles_o increments each cycle.
  - If decryption_readyxSI=1, go to DELAY and freeze cycles_o. Ready already high on WAIT entry is taken in the first WAIT cycle.
  - If TIMEOUT WAIT cycles pass without ready, go to ERR with err=1 and busy=0.
  - cycles_o saturates at 16'hFFFF.
- DELAY: READ_DELAY cycles, then READ with ctr=0.
- READ: MAX cycles, LSB-first capture.
  - pt_o[ctr]<=plain_textxSI if ctr<Y.
  - tag_o[ctr]<=tagxSI if ctr<128.
  - Bits beyond these widths are discarded.
- DONE: done=1 for exactly one cycle, then IDLE. pt_o/tag_o hold until the next accepted start.
- Total latency with defaults: 1 + MAX + START_HOLD + WAIT + READ_DELAY + MAX + 1 cycles.

Test Plan:
- Load ordering: K=128, L=Y=40, KEY=3ffa75efbd1705fa8f9ced62e5bb0be3, NONCE=9691163337dd55217ea2a6b21eaa19b2, AD=4153434f4e, CT=c21061905f -> 128 LOAD cycles. In cycle i: keyxSO[0]=KEY[127-i], cipher_textxSO[0]=CT[39-i] for i<40 and 0 for i>=40. Random lanes equal the reference LFSR model from SEED.
- End to end with Ascon (TI=1, FP=0) using the same vectors -> pt_o=40'h0000000000, exactly one done pulse, cycles_o equals the core's measured latency, err=0.
- Capture order with a stub core: plain_textxSI=i%2 and tagxSI=(i<64) in READ cycle i -> pt_o=40'hAAAAAAAAAA and tag_o=128'h0000000000000000FFFFFFFFFFFFFFFF.
- Timeout: TIMEOUT=100, ready tied 0 -> err=1 and busy=0 after 100 WAIT cycles, no done. A subsequent start clears err and runs normally.
- Async reset mid-LOAD (ctr=50) -> all outputs 0 without waiting for a clock edge. After release, a new start reloads from ctr=0 with LFSR=SEED.
- start re-asserted during WAIT with different inputs -> ignored; outputs reflect the first latched vector.

Source files
------------

// File: rtl/ascon_serial_host.sv
// Host-side serial driver for the Ascon decryption core.
// Loads key/nonce/AD/CT serially with LFSR shares, then reads PT/tag back.
module ascon_serial_host #(
  parameter int          K          = 128,
  parameter int          L          = 40,
  parameter int          Y          = 40,
  parameter int          START_HOLD = 3,
  parameter int          READ_DELAY = 2,
  parameter int          TIMEOUT    = 4096,
  parameter logic [31:0] SEED       = 32'hACE1_5EED
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K-1:0]   key_i,
  input  logic [127:0]   nonce_i,
  input  logic [L-1:0]   ad_i,
  input  logic [Y-1:0]   ct_i,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [Y-1:0]   pt_o,
  output logic [127:0]   tag_o,
  output logic [15:0]    cycles_o,
  output logic [2:0]     keyxSO,
  output logic [2:0]     noncexSO,
  output logic [2:0]     associated_dataxSO,
  output logic [2:0]     cipher_textxSO,
  output logic [6:0]     r_64xSO,
  output logic           r_128xSO,
  output logic           r_ptxSO,
  output logic           decryption_startxSO,
  input  logic           plain_textxSI,
  input  logic           tagxSI,
  input  logic           decryption_readyxSI
);

  localparam int MAX = (K > L) ? ((K > Y) ? K : Y)
                               : ((L > Y) ? L : Y);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [15:0]   LAST    = 16'(MAX - 1);
  localparam logic [15:0]   SH_LAST = 16'(START_HOLD - 1);
  localparam logic [15:0]   RD_LAST = 16'(READ_DELAY - 1);
  localparam logic [15:0]   PT_LEN  = 16'(Y);
  localparam logic [15:0]   TAG_LEN = 16'd128;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0]   TAPS    = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DELAY,
    S_READ,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, nextState;

  logic [15:0]   ctr;
  logic [TW-1:0] waitCtr;
  logic [31:0]   lfsr, lfsrStep;
  logic [K-1:0]  keySh;
  logic [127:0]  nonceSh;
  logic [L-1:0]  adSh;
  logic [Y-1:0]  ctSh;

  logic        accept;
  logic        inLoad;
  logic        loadNext;
  logic        timeout;
  logic [16:0] rndNext;
  logic [3:0]  datNext;

  assign accept  = start && (state == S_IDLE || state == S_ERR);
  assign inLoad  = (state == S_LOAD);
  assign timeout = (state == S_WAIT) && !decryption_readyxSI
                   && (waitCtr == TO_LAST);

  assign busy = (state != S_IDLE) && (state != S_ERR);
  assign done = (state == S_DONE);
  assign decryption_startxSO = (state == S_START);

  assign lfsrStep = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE, S_ERR:
        if (start) nextState = S_LOAD;
      S_LOAD:
        if (ctr == LAST) nextState = S_START;
      S_START:
        if (ctr == SH_LAST) nextState = S_WAIT;
      S_WAIT:
        if (decryption_readyxSI) nextState = S_DELAY;
        else if (timeout)        nextState = S_ERR;
      S_DELAY:
        if (ctr == RD_LAST) nextState = S_READ;
      S_READ:
        if (ctr == LAST) nextState = S_DONE;
      S_DONE:
        nextState = S_IDLE;
      default:
        nextState = S_IDLE;
    endcase
  end

  // Lane values for the coming cycle, so the serial outputs are flops.
  always_comb begin
    loadNext = (nextState == S_LOAD);
    rndNext  = '0;
    datNext  = '0;
    if (loadNext) begin
      rndNext = inLoad ? lfsrStep[16:0] : lfsr[16:0];
      if (inLoad)
        datNext = {keySh[K-2], nonceSh[126], adSh[L-2], ctSh[Y-2]};
      else
        datNext = {key_i[K-1], nonce_i[127], ad_i[L-1], ct_i[Y-1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr                <= '0;
      waitCtr            <= '0;
      lfsr               <= SEED;
      keySh              <= '0;
      nonceSh            <= '0;
      adSh               <= '0;
      ctSh               <= '0;
      err                <= 1'b0;
      pt_o               <= '0;
      tag_o              <= '0;
      cycles_o           <= '0;
      keyxSO             <= '0;
      noncexSO           <= '0;
      associated_dataxSO <= '0;
      cipher_textxSO     <= '0;
      r_64xSO            <= '0;
      r_128xSO           <= 1'b0;
      r_ptxSO            <= 1'b0;
    end else begin
      if (nextState != state)
        ctr <= '0;
      else if (state inside {S_LOAD, S_START, S_DELAY, S_READ})
        ctr <= ctr + 16'd1;

      if (state == S_WAIT) waitCtr <= waitCtr + 1'b1;
      else                 waitCtr <= '0;

      if (accept) begin
        keySh    <= key_i;
        nonceSh  <= nonce_i;
        adSh     <= ad_i;
        ctSh     <= ct_i;
        err      <= 1'b0;
        cycles_o <= '0;
        pt_o     <= '0;
        tag_o    <= '0;
      end else if (inLoad) begin
        keySh   <= keySh << 1;
        nonceSh <= nonceSh << 1;
        adSh    <= adSh << 1;
        ctSh    <= ctSh << 1;
        lfsr    <= lfsrStep;
      end

      // Count includes the cycle in which ready is seen.
      if (state == S_START || state == S_WAIT) begin
        if (cycles_o != 16'hFFFF) cycles_o <= cycles_o + 16'd1;
      end

      if (timeout) err <= 1'b1;

      if (state == S_READ) begin
        if (ctr < PT_LEN)  pt_o  <= {plain_textxSI, pt_o[Y-1:1]};
        if (ctr < TAG_LEN) tag_o <= {tagxSI, tag_o[127:1]};
      end

      keyxSO             <= {rndNext[7:6], datNext[3]};
      noncexSO           <= {rndNext[1:0], datNext[2]};
      associated_dataxSO <= {rndNext[5:4], datNext[1]};
      cipher_textxSO     <= {rndNext[3:2], datNext[0]};
      r_64xSO            <= rndNext[14:8];
      r_ptxSO            <= rndNext[15];
      r_128xSO           <= rndNext[16];
    end
  end

endmodule
